fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode state machine.
//  - Owns the 32-bit PC and drives the instruction-memory read address.
//  - Boots the PC from a vector in instruction memory.
//  - Selects the next PC from sequential, jump or memory (RET/RETI) sources.
//  - Latches external interrupts and delivers them to decode as a one-cycle interrupt_signal.
//  - Handles decode's clear_instruction (LDM immediate capture / NOP injection).

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, boot-vector loader, next-PC select, interrupt latch and IF/ID register.
// Optional FETCH_STATS_EN adds saturating fetch/flush counters.
module fetch_stage #(
    parameter logic [15:0] NOP_WORD  = 16'h4000,
    parameter logic [31:0] BOOT_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_mem_addr,
    input  logic [15:0] instr_mem_data,
    input  logic        stall,
    input  logic        clear_instruction,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        pc_choose_memory,
    input  logic [31:0] mem_pc,
    input  logic        interrupt_in,
    output logic        interrupt_signal,
    output logic [15:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [15:0] if_id_imm,
    output logic        if_id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);
    typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ifpc_q, ifpc_d;
    logic [15:0] ins_q, ins_d, imm_q, imm_d;
    logic        valid_q, valid_d, irq_q, irq_d;
    logic        run, redirect;
    assign run      = state_q == RUN;
    assign redirect = pc_choose_memory | jump_taken;
    assign instr_mem_addr    = state_q == BOOT_HI ? BOOT_ADDR : state_q == BOOT_LO ? BOOT_ADDR + 32'd1 : pc_q;
    assign interrupt_signal  = run & irq_q & ~stall & ~redirect;
    assign if_id_instruction = ins_q;
    assign if_id_pc          = ifpc_q;
    assign if_id_imm         = imm_q;
    assign if_id_valid       = valid_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        ifpc_d  = ifpc_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        irq_d   = (irq_q & ~interrupt_signal) | interrupt_in;
        case (state_q)
            BOOT_HI: begin
                state_d      = BOOT_LO;
                pc_d[31:16]  = instr_mem_data;
            end
            BOOT_LO: begin
                state_d      = RUN;
                pc_d[15:0]   = instr_mem_data;
            end
            default: begin
                if (redirect) begin
                    pc_d    = pc_choose_memory ? mem_pc : jump_target;
                    ins_d   = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd1;
                    ins_d   = clear_instruction ? NOP_WORD : instr_mem_data;
                    valid_d = ~clear_instruction;
                    imm_d   = clear_instruction ? instr_mem_data : imm_q;
                    ifpc_d  = clear_instruction ? ifpc_q : pc_q + 32'd1;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT_HI;
            pc_q    <= '0;
            ins_q   <= NOP_WORD;
            ifpc_q  <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            ifpc_q  <= ifpc_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            irq_q   <= irq_d;
        end
    end
`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
    logic        fetch_ev, flush_ev;
    assign fetch_ev     = run & ~redirect & ~stall & ~clear_instruction;
    assign flush_ev     = run & (redirect | (~stall & clear_instruction));
    assign fetched_d    = fetched_q + {31'd0, fetch_ev && fetched_q != '1};
    assign flushed_d    = flushed_q + {31'd0, flush_ev && flushed_q != '1};
    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand-written reset sequence and randomized run
// against a behavioural model of the fetch stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_mem_addr;
    logic [15:0] instr_mem_data;
    logic        stall, clear_instruction, jump_taken, pc_choose_memory, interrupt_in;
    logic [31:0] jump_target, mem_pc;
    logic        interrupt_signal, if_id_valid;
    logic [15:0] if_id_instruction, if_id_imm;
    logic [31:0] if_id_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushed;
`endif
    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .instr_mem_addr(instr_mem_addr), .instr_mem_data(instr_mem_data),
        .stall(stall), .clear_instruction(clear_instruction), .jump_taken(jump_taken),
        .jump_target(jump_target), .pc_choose_memory(pc_choose_memory), .mem_pc(mem_pc),
        .interrupt_in(interrupt_in), .interrupt_signal(interrupt_signal),
        .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc), .if_id_imm(if_id_imm),
        .if_id_valid(if_id_valid)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    always #5 clk = ~clk;
    assign instr_mem_data = mem[instr_mem_addr[7:0]];

    typedef struct {
        int unsigned st, cl, jp, pm, iq, jt, mp;
        int unsigned a, ins, ip, im, v, it;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.st != 0;
        clear_instruction = v.cl != 0;
        jump_taken = v.jp != 0;
        pc_choose_memory = v.pm != 0;
        interrupt_in = v.iq != 0;
        jump_target = v.jt;
        mem_pc = v.mp;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, instr_mem_addr, 32'h0);
        chk({tag, "_ins"}, {16'h0, if_id_instruction}, 32'h4000);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_imm"}, {16'h0, if_id_imm}, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_int"}, {31'h0, interrupt_signal}, 32'h0);
    endtask

    // behavioural model state
    int unsigned m_phase;
    logic [31:0] m_pc, m_ifpc, e_addr, fe_cnt, fl_cnt;
    logic [15:0] m_ins, m_imm, d;
    logic        m_v, m_pend, e_int;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h0000;
        mem[1] = 16'h0010;
        mem[8'h40] = 16'hBEEF;
        //           st cl jp pm iq jt     mp     addr   ins      ip     imm      v  int
        tbl.push_back('{1, 0, 1, 0, 0, 'h99, 0,    'h0,   'h4000, 0,     0,       0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0,    0,    'h1,   'h4000, 0,     0,       0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h10,  'h4000, 0,     0,       0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h11,  'hA010, 'h11,  0,       1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h12,  'hA011, 'h12,  0,       1, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 'h40, 0,    'h13,  'hA012, 'h13,  0,       1, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0,    0,    'h40,  'h4000, 0,     0,       0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h41,  'h4000, 0,     'hBEEF,  0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 0,    0,    'h42,  'hA041, 'h42,  'hBEEF,  1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0,    0,    'h42,  'hA041, 'h42,  'hBEEF,  1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0,    0,    'h42,  'hA041, 'h42,  'hBEEF,  1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h42,  'hA041, 'h42,  'hBEEF,  1, 1});
        tbl.push_back('{0, 0, 1, 1, 0, 'h40, 'h20, 'h43,  'hA042, 'h43,  'hBEEF,  1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0,    0,    'h20,  'h4000, 0,     'hBEEF,  0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 'h50, 0,    'h21,  'hA020, 'h21,  'hBEEF,  1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h50,  'h4000, 0,     'hBEEF,  0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0,    0,    'h51,  'hA050, 'h51,  'hBEEF,  1, 0});

        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_addr", i), instr_mem_addr, tbl[i].a);
            chk($sformatf("v%0d_ins", i), {16'h0, if_id_instruction}, tbl[i].ins);
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, tbl[i].v);
            chk($sformatf("v%0d_imm", i), {16'h0, if_id_imm}, tbl[i].im);
            chk($sformatf("v%0d_int", i), {31'h0, interrupt_signal}, tbl[i].it);
            if (tbl[i].v != 0) chk($sformatf("v%0d_pc", i), if_id_pc, tbl[i].ip);
            @(negedge clk);
        end

        // async reset mid-cycle while an interrupt is pending
        drive('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        interrupt_in = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("reboot%0d_addr", k), instr_mem_addr, k == 2 ? 32'h10 : 32'(k));
            chk($sformatf("reboot%0d_int", k), {31'h0, interrupt_signal}, 32'h0);
            @(negedge clk);
        end

        // randomized run against the model
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_phase = 0; m_pc = 0; m_ifpc = 0; m_ins = 16'h4000; m_imm = 0; m_v = 0; m_pend = 0;
        fe_cnt = 0; fl_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            stall = $urandom_range(0, 3) == 0;
            clear_instruction = $urandom_range(0, 6) == 0;
            jump_taken = $urandom_range(0, 9) == 0;
            pc_choose_memory = $urandom_range(0, 19) == 0;
            interrupt_in = $urandom_range(0, 9) == 0;
            jump_target = $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFFD + $urandom_range(0, 2);
            mem_pc = $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFFE;
            e_addr = m_phase == 0 ? 32'h0 : m_phase == 1 ? 32'h1 : m_pc;
            e_int = m_phase == 2 && m_pend && !stall && !jump_taken && !pc_choose_memory;
            d = mem[e_addr[7:0]];
            #1;
            chk("rnd_addr", instr_mem_addr, e_addr);
            chk("rnd_int", {31'h0, interrupt_signal}, {31'h0, e_int});
            chk("rnd_ins", {16'h0, if_id_instruction}, {16'h0, m_ins});
            chk("rnd_valid", {31'h0, if_id_valid}, {31'h0, m_v});
            chk("rnd_imm", {16'h0, if_id_imm}, {16'h0, m_imm});
            if (m_v) chk("rnd_pc", if_id_pc, m_ifpc);
            @(posedge clk);
            if (m_phase == 0) begin
                m_pc = {d, m_pc[15:0]};
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_pc = {m_pc[31:16], d};
                m_phase = 2;
            end else if (pc_choose_memory || jump_taken) begin
                m_pc = pc_choose_memory ? mem_pc : jump_target;
                m_ins = 16'h4000; m_v = 0; fl_cnt++;
            end else if (stall) begin
            end else if (clear_instruction) begin
                m_imm = d; m_ins = 16'h4000; m_v = 0; m_pc = m_pc + 1; fl_cnt++;
            end else begin
                m_ins = d; m_ifpc = m_pc + 1; m_v = 1; m_pc = m_pc + 1; fe_cnt++;
            end
            m_pend = (m_pend && !e_int) || interrupt_in;
            @(negedge clk);
        end
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, fe_cnt);
        chk("stat_flushed", stat_flushed, fl_cnt);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
